// File: rtl/cdc_afifo_pkg.sv
// Shared definitions for the read-side drain engine of the dual-clock FIFO.
// Holds the elastic-buffer occupancy encoding and the payload field helper.
package cdc_afifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  // The MSB of every FIFO word carries the end-of-packet flag.
  function automatic int last_bit(input int dbits);
    return dbits - 1;
  endfunction

endpackage

// File: rtl/cdc_skid2.sv
// Two-entry elastic buffer between the show-ahead FIFO read port and a valid/ready stream.
// Entry 0 is always the head; a fetched word lands in the first free slot after any pop.
module cdc_skid2
  import cdc_afifo_pkg::*;
#(
  parameter int width = 65
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_empty,
  input  logic [width-1:0] i_data,
  input  logic             i_ready,
  output logic             o_fetch,
  output logic             o_pop,
  output logic             o_valid,
  output logic [width-1:0] o_head
);

  occ_e             r_state;
  logic [width-1:0] r_ent0;
  logic [width-1:0] r_ent1;
  logic             w_pop;
  logic             w_fetch;

  assign o_valid = (r_state != EMPTY);
  assign w_pop   = o_valid & i_ready;
  // Reset gates the strobe so the FIFO is never popped while the buffer is held clear.
  assign w_fetch = ~i_rst & ~i_empty & ~i_flush & ((r_state != FULL) | w_pop);

  assign o_fetch = w_fetch;
  assign o_pop   = w_pop;
  assign o_head  = r_ent0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= EMPTY;
      r_ent0  <= '0;
      r_ent1  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_fetch) begin
            r_ent0  <= i_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_fetch && w_pop) begin
            r_ent0 <= i_data;
          end else if (w_fetch) begin
            r_ent1  <= i_data;
            r_state <= FULL;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_ent0 <= r_ent1;
            if (w_fetch) begin
              r_ent1 <= i_data;
            end else begin
              r_state <= ONE;
            end
          end
        end
        default: r_state <= EMPTY;
      endcase
      if (i_flush) begin
        r_state <= EMPTY;
      end
    end
  end

endmodule

// File: rtl/cdc_afifo_reader.sv
// Read-domain drain engine: pops the FIFO into a 2-entry buffer, splits off the
// end-of-packet flag and keeps wrapping word/packet counters of accepted words.
module cdc_afifo_reader
  import cdc_afifo_pkg::*;
#(
  parameter int dbits   = 65,
  parameter int cntbits = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_fifo_rd,
  input  logic [dbits-1:0]   i_fifo_rdata,
  input  logic               i_fifo_rempty,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [dbits-2:0]   o_data,
  output logic               o_last,
  output logic [cntbits-1:0] o_word_cnt,
  output logic [cntbits-1:0] o_pkt_cnt
);

  localparam int LB = last_bit(dbits);

  logic             w_pop;
  logic [dbits-1:0] w_head;
  logic [cntbits-1:0] r_word_cnt;
  logic [cntbits-1:0] r_pkt_cnt;

  cdc_skid2 #(
    .width(dbits)
  ) u_skid (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_flush(i_flush),
    .i_empty(i_fifo_rempty),
    .i_data (i_fifo_rdata),
    .i_ready(i_ready),
    .o_fetch(o_fifo_rd),
    .o_pop  (w_pop),
    .o_valid(o_valid),
    .o_head (w_head)
  );

  assign o_data = w_head[LB-1:0];
  assign o_last = w_head[LB];

  // A pop in a flush cycle still counts: downstream has already taken the word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + cntbits'(1);
      if (o_last) begin
        r_pkt_cnt <= r_pkt_cnt + cntbits'(1);
      end
    end
  end

  assign o_word_cnt = r_word_cnt;
  assign o_pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_cdc_afifo_reader.sv
// Self-checking bench for cdc_afifo_reader: directed tables and sequences plus a random
// phase, all judged against a queue-based model of the FIFO and the 2-word buffer.
module tb_cdc_afifo_reader;

  logic        clk;
  logic        rst;
  logic [64:0] rdata;
  logic        rempty;
  logic        flush;
  logic        ready;

  logic        fifoRd,  fifoRdW;
  logic        valid,   validW;
  logic [63:0] data,    dataW;
  logic        last,    lastW;
  logic [31:0] wordCnt, pktCnt;
  logic [3:0]  wordCntW, pktCntW;

  cdc_afifo_reader dut (
    .i_clk(clk), .i_rst(rst), .o_fifo_rd(fifoRd), .i_fifo_rdata(rdata),
    .i_fifo_rempty(rempty), .i_flush(flush), .o_valid(valid), .i_ready(ready),
    .o_data(data), .o_last(last), .o_word_cnt(wordCnt), .o_pkt_cnt(pktCnt)
  );

  // Narrow-counter copy sharing the same inputs exercises modulo-16 wrap.
  cdc_afifo_reader #(.dbits(65), .cntbits(4)) dutW (
    .i_clk(clk), .i_rst(rst), .o_fifo_rd(fifoRdW), .i_fifo_rdata(rdata),
    .i_fifo_rempty(rempty), .i_flush(flush), .o_valid(validW), .i_ready(ready),
    .o_data(dataW), .o_last(lastW), .o_word_cnt(wordCntW), .o_pkt_cnt(pktCntW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [64:0] fifoQ[$];
  logic [64:0] bufQ[$];
  int unsigned wc;
  int unsigned pc;
  logic curReady, curFlush, curHold;

  typedef struct {
    logic        ready;
    logic        expRd;
    logic        expValid;
    logic [63:0] expData;
    logic        expLast;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic h);
    @(negedge clk);
    ready    = r;
    flush    = f;
    curReady = r;
    curFlush = f;
    curHold  = h;
    if (fifoQ.size() > 0 && !h) begin
      rempty = 1'b0;
      rdata  = fifoQ[0];
    end else begin
      rempty = 1'b1;
      rdata  = {1'($urandom_range(1, 0)), $urandom, $urandom};
    end
    #1;
  endtask

  // Compare against the model, then advance the model by one clock edge.
  task automatic checkOutput();
    int    sz;
    logic  visible, expRd, popM;
    sz      = bufQ.size();
    visible = (fifoQ.size() > 0) && !curHold;
    popM    = (sz > 0) && curReady;
    expRd   = visible && !curFlush && ((sz < 2) || popM);
    check("valid", 65'(valid), 65'(sz > 0));
    check("validW", 65'(validW), 65'(sz > 0));
    if (sz > 0) begin
      check("head", {last, data}, bufQ[0]);
      check("headW", {lastW, dataW}, bufQ[0]);
    end
    check("fifo_rd", 65'(fifoRd), 65'(expRd));
    check("fifo_rdW", 65'(fifoRdW), 65'(expRd));
    check("word_cnt", 65'(wordCnt), 65'(wc));
    check("pkt_cnt", 65'(pktCnt), 65'(pc));
    check("word_cntW", 65'(wordCntW), 65'(wc % 16));
    check("pkt_cntW", 65'(pktCntW), 65'(pc % 16));
    if (popM) begin
      wc++;
      if (bufQ[0][64]) pc++;
      void'(bufQ.pop_front());
    end
    if (expRd) bufQ.push_back(fifoQ.pop_front());
    if (curFlush) bufQ.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst    = 1'b1;
    ready  = 1'b1;
    flush  = 1'b0;
    rempty = 1'b0;
    rdata  = {1'b1, $urandom, $urandom};
    #1;
    check("rst_fifo_rd", 65'(fifoRd), 65'(0));
    check("rst_valid", 65'(valid), 65'(0));
    check("rst_word_cnt", 65'(wordCnt), 65'(0));
    check("rst_pkt_cnt", 65'(pktCnt), 65'(0));
    check("rst_head", {last, data}, 65'(0));
    repeat (2) begin
      @(negedge clk);
      #1;
      check("rst_hold_fifo_rd", 65'(fifoRd), 65'(0));
    end
    @(negedge clk);
    rst    = 1'b0;
    rempty = 1'b1;
    bufQ.delete();
    wc = 0;
    pc = 0;
  endtask

  initial begin
    int rdCount;
    rst = 1'b1; ready = 1'b0; flush = 1'b0; rempty = 1'b1; rdata = '0;
    curReady = 1'b0; curFlush = 1'b0; curHold = 1'b0;
    wc = 0; pc = 0;

    for (int k = 0; k < 10; k++) begin
      vecs[k].ready    = 1'b1;
      vecs[k].expRd    = (k < 8);
      vecs[k].expValid = (k >= 1) && (k <= 8);
      vecs[k].expData  = vecs[k].expValid ? 64'(32'h10 + k - 1) : 64'h0;
      vecs[k].expLast  = (k == 8);
    end

    // Reset with a word waiting, then the first cycle after release must fetch it.
    fifoQ.push_back({1'b0, 64'hAA});
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    check("release_fifo_rd", 65'(fifoRd), 65'(1));
    checkOutput();
    repeat (3) begin applyStimulus(1'b1, 1'b0, 1'b0); checkOutput(); end

    // Streaming table: 8 words, last on the 8th.
    doReset();
    for (int k = 0; k < 8; k++) fifoQ.push_back({(k == 7), 64'(32'h10 + k)});
    for (int k = 0; k < 10; k++) begin
      applyStimulus(vecs[k].ready, 1'b0, 1'b0);
      check("tbl_fifo_rd", 65'(fifoRd), 65'(vecs[k].expRd));
      check("tbl_valid", 65'(valid), 65'(vecs[k].expValid));
      if (vecs[k].expValid) check("tbl_head", {last, data}, {vecs[k].expLast, vecs[k].expData});
      checkOutput();
    end
    check("stream_word_cnt", 65'(wordCnt), 65'(8));
    check("stream_pkt_cnt", 65'(pktCnt), 65'(1));

    // Backpressure: 5 stalled cycles pop exactly two words and hold the head.
    doReset();
    for (int k = 0; k < 10; k++) fifoQ.push_back({(k == 9), 64'(32'h100 + k)});
    rdCount = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (fifoRd) rdCount++;
      if (k >= 1) check("bp_head", {last, data}, {1'b0, 64'h100});
      checkOutput();
    end
    check("bp_rd_count", 65'(rdCount), 65'(2));
    repeat (13) begin applyStimulus(1'b1, 1'b0, 1'b0); checkOutput(); end
    check("bp_word_cnt", 65'(wordCnt), 65'(10));

    // Empty boundary: head visible only every other cycle.
    doReset();
    for (int k = 0; k < 6; k++) fifoQ.push_back({(k == 5), 64'(32'h300 + k)});
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 1'b0, (k % 2) == 0);
      check("rd_while_empty", 65'(fifoRd & rempty), 65'(0));
      checkOutput();
    end
    check("alt_word_cnt", 65'(wordCnt), 65'(6));

    // Flush in FULL with a pop in the same cycle.
    doReset();
    for (int k = 0; k < 5; k++) fifoQ.push_back({1'b0, 64'(32'h200 + k)});
    repeat (2) begin applyStimulus(1'b0, 1'b0, 1'b0); checkOutput(); end
    applyStimulus(1'b1, 1'b1, 1'b0);
    check("flush_no_rd", 65'(fifoRd), 65'(0));
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b0);
    check("flush_valid", 65'(valid), 65'(0));
    check("flush_word_cnt", 65'(wordCnt), 65'(1));
    checkOutput();
    applyStimulus(1'b1, 1'b0, 1'b0);
    check("flush_next_head", {last, data}, {1'b0, 64'h202});
    checkOutput();
    repeat (3) begin applyStimulus(1'b1, 1'b0, 1'b0); checkOutput(); end

    // Counter wrap on the 4-bit copy after 17 pops.
    doReset();
    for (int k = 0; k < 17; k++) fifoQ.push_back({1'b1, 64'(32'h400 + k)});
    repeat (20) begin applyStimulus(1'b1, 1'b0, 1'b0); checkOutput(); end
    check("wrap_word_cntW", 65'(wordCntW), 65'(1));
    check("wrap_pkt_cntW", 65'(pktCntW), 65'(1));
    check("wrap_word_cnt", 65'(wordCnt), 65'(17));

    // Random traffic with occasional flushes and head hold-offs.
    doReset();
    for (int k = 0; k < 400; k++) begin
      if (fifoQ.size() < 4 && $urandom_range(3, 0) != 0)
        fifoQ.push_back({1'($urandom_range(1, 0)), $urandom, $urandom});
      applyStimulus($urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0,
                    $urandom_range(9, 0) < 3);
      checkOutput();
      if (k == 200) begin
        doReset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_afifo_reader.md
# cdc_afifo_reader

Read-side drain engine for the dual-clock FIFO, running entirely in the read clock domain. It pops words from the FIFO read port whenever it has room and holds them in a 2-entry elastic buffer. It presents them downstream as a valid/ready stream, splitting the payload MSB off as an end-of-packet flag, and keeps word and packet counters for status registers.

## Interface
Parameters:
- dbits, 65: FIFO payload width; bit dbits-1 is the last flag, bits dbits-2:0 are data.
- cntbits, 32: width of the status counters.

Ports:
- i_clk  in  1  read-domain clock; all logic is on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- o_fifo_rd  out  1  FIFO pop strobe.
- i_fifo_rdata  in  dbits  FIFO head word; valid in the same cycle whenever i_fifo_rempty=0 (show-ahead).
- i_fifo_rempty  in  1  FIFO empty flag, synchronized to the read domain.
- i_flush  in  1  synchronous discard of buffered words.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts the word.
- o_data  out  dbits-1  output data.
- o_last  out  1  end-of-packet flag.
- o_word_cnt  out  cntbits  count of accepted words; wraps.
- o_pkt_cnt  out  cntbits  count of accepted words with last=1; wraps.

## Operation
- Buffer occupancy state is one of EMPTY (0), ONE (1) or FULL (2). Entry 0 is the head and drives o_data and o_last from registers.
- pop = o_valid & i_ready.
- fetch = ~i_fifo_rempty & ~i_flush & (state!=FULL | pop).
- o_fifo_rd = fetch. It is combinational and must never be high while i_fifo_rempty=1.
- On fetch, i_fifo_rdata is captured in the same cycle into the first free slot, counted after the pop has been applied.
- State transitions:
  - EMPTY: fetch moves to ONE; otherwise stays.
  - ONE: fetch without pop moves to FULL; pop without fetch moves to EMPTY; both or neither stay.
  - FULL: pop with fetch stays FULL (entry1 shifts to head and the new word goes to entry1); pop without fetch moves to ONE; no pop stays FULL.
- o_valid = (state!=EMPTY).
- Once o_valid rises, o_data and o_last must stay stable until pop.
- Counters:
  - o_word_cnt += 1 on every pop.
  - o_pkt_cnt += 1 on pop when o_last=1.
  - Both wrap modulo 2^cntbits with no saturation.
- Flush:
  - i_flush=1 moves the state to EMPTY on the next edge and suppresses fetch.
  - A pop in the flush cycle is still counted, because downstream sampled the word.
  - Words remaining in the FIFO are not drained by flush.
- Reset values: state EMPTY, o_valid 0, o_data 0, o_last 0, o_word_cnt 0, o_pkt_cnt 0, buffer entries 0. o_fifo_rd is 0 for the whole time i_rst=1.
- Reset asserted mid-stream clears everything immediately; partially consumed packets are not tracked.

## Timing
- Latency: a word at the FIFO head with i_fifo_rempty=0 at edge N (fetch high in cycle N) gives o_valid=1 in the cycle after edge N+1, i.e. 1 cycle.
- Throughput is 1 word/cycle sustained with i_ready held at 1; there are no bubbles in the FULL state.
- Ready has no combinational path to o_valid or o_data. i_ready does feed o_fifo_rd combinationally in the FULL state; this is accepted.
- Counters update on the edge that ends the pop cycle and are visible in the following cycle.

## Structure
- Shared package cdc_afifo_pkg holds:
  - the occupancy enum (EMPTY=2'd0, ONE=2'd1, FULL=2'd2);
  - the field position constant LAST_BIT = dbits-1 helper.
- A single sub-module, cdc_skid2, is natural. It is the 2-entry elastic buffer: data, state and pop/fetch logic, plus flush. Counters and the payload split live in the top.

## Test plan
- Reset: hold i_rst=1 with i_fifo_rempty=0 -> o_fifo_rd=0, o_valid=0, counters 0. Release -> o_fifo_rd=1 in the first cycle.
- Streaming: 8 words with data 0x10..0x17, last on the 8th, i_ready=1 -> output in order at 1/cycle with 1-cycle latency; o_word_cnt=8, o_pkt_cnt=1.
- Backpressure: i_ready=0 for 5 cycles with the FIFO non-empty -> exactly 2 pops, then o_fifo_rd=0 and head data stable. Raise i_ready -> no loss or duplication, sequence intact.
- Empty boundary: FIFO delivers alternate words (rempty toggles every cycle) -> o_fifo_rd never high while rempty=1, and words arrive correctly.
- Flush in FULL with pop in the same cycle -> o_word_cnt +1, state EMPTY next cycle, and the next output is the next FIFO word.
- Counter wrap: cntbits=4, 17 pops -> o_word_cnt=1.
